// File: rtl/serial_recoupler_if.sv
// Handshake bundles for the serial recoupler: per-lane tagged
// element streams in, reassembled multi-element beats out.
interface tagged_i #(
    parameter type data_t       = logic [31:0],
    parameter int  SERIAL_WIDTH = 6
);
    data_t                   data;
    logic [SERIAL_WIDTH-1:0] tag;
    logic                    keep;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport m (output data, tag, keep, last, valid, input ready);
    modport s (input data, tag, keep, last, valid, output ready);
endinterface

interface ndata_i #(
    parameter type data_t       = logic [31:0],
    parameter int  NUM_ELEMENTS = 4
);
    data_t                   data [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] keep;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/serial_recoupler.sv
// Serial recoupler: reorders tagged per-element lane traffic back
// into complete, in-order NUM_ELEMENTS-wide beats.
module serial_recoupler #(
    parameter type data_t       = logic [31:0],
    parameter int  NUM_ELEMENTS = 4,
    parameter int  SERIAL_WIDTH = 6
) (
    input logic clk,
    input logic rst,
    tagged_i.s  in [NUM_ELEMENTS],
    ndata_i.m   out
);
    localparam int DATA_BITS  = $clog2(NUM_ELEMENTS);
    localparam int BEAT_BITS  = SERIAL_WIDTH - DATA_BITS;
    localparam int BEAT_SLOTS = 2 ** BEAT_BITS;

    typedef logic [DATA_BITS-1:0]    elem_t;
    typedef logic [BEAT_BITS-1:0]    beat_t;
    typedef logic [NUM_ELEMENTS-1:0] row_t;

    data_t lane_data [NUM_ELEMENTS];
    elem_t lane_elem [NUM_ELEMENTS];
    beat_t lane_beat [NUM_ELEMENTS];
    row_t  lane_keep;
    row_t  lane_last;
    row_t  lane_valid;
    row_t  lane_ready;
    row_t  lane_acc;
    row_t  col_claim;

    data_t mem_data_q [BEAT_SLOTS][NUM_ELEMENTS];
    data_t mem_data_d [BEAT_SLOTS][NUM_ELEMENTS];
    row_t  mem_keep_q [BEAT_SLOTS];
    row_t  mem_keep_d [BEAT_SLOTS];
    logic  mem_last_q [BEAT_SLOTS];
    logic  mem_last_d [BEAT_SLOTS];

    row_t  present_q [BEAT_SLOTS];
    row_t  present_d [BEAT_SLOTS];
    beat_t head_q;
    beat_t head_d;
    logic  out_valid_q;
    logic  out_valid_d;
    data_t out_data_q [NUM_ELEMENTS];
    data_t out_data_d [NUM_ELEMENTS];
    row_t  out_keep_q;
    row_t  out_keep_d;
    logic  out_last_q;
    logic  out_last_d;
    logic  complete;
    logic  emit;

    for (genvar l = 0; l < NUM_ELEMENTS; l++) begin : g_lane
        assign lane_data[l]  = in[l].data;
        assign lane_elem[l]  = in[l].tag[DATA_BITS-1:0];
        assign lane_beat[l]  = in[l].tag[SERIAL_WIDTH-1:DATA_BITS];
        assign lane_keep[l]  = in[l].keep;
        assign lane_last[l]  = in[l].last;
        assign lane_valid[l] = in[l].valid;
        assign in[l].ready   = lane_ready[l];
        assign out.data[l]   = out_data_q[l];
    end

    assign out.keep  = out_keep_q;
    assign out.last  = out_last_q;
    assign out.valid = out_valid_q;

    // One write port per column: a valid lower lane claims it first.
    always_comb begin
        lane_ready = '0;
        col_claim  = '0;
        for (int l = 0; l < NUM_ELEMENTS; l++) begin
            lane_ready[l] = !rst
                && !present_q[lane_beat[l]][lane_elem[l]]
                && !col_claim[lane_elem[l]];
            if (lane_valid[l]) begin
                col_claim[lane_elem[l]] = 1'b1;
            end
        end
        lane_acc = lane_valid & lane_ready;
    end

    always_comb begin
        mem_data_d = mem_data_q;
        mem_keep_d = mem_keep_q;
        mem_last_d = mem_last_q;
        for (int l = 0; l < NUM_ELEMENTS; l++) begin
            if (lane_acc[l]) begin
                mem_data_d[lane_beat[l]][lane_elem[l]] = lane_data[l];
                mem_keep_d[lane_beat[l]][lane_elem[l]] = lane_keep[l];
                if (lane_elem[l] == '0) begin
                    mem_last_d[lane_beat[l]] = lane_last[l];
                end
            end
        end
    end

    always_comb begin
        present_d   = present_q;
        head_d      = head_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        complete    = &present_q[head_q];
        emit        = complete && (!out_valid_q || out.ready);
        if (emit) begin
            out_data_d          = mem_data_q[head_q];
            out_keep_d          = mem_keep_q[head_q];
            out_last_d          = mem_last_q[head_q];
            out_valid_d         = 1'b1;
            present_d[head_q]   = '0;
            head_d              = head_q + beat_t'(1);
        end else if (out.ready) begin
            out_valid_d = 1'b0;
        end
        // Accepted slots are never the head row being freed here.
        for (int l = 0; l < NUM_ELEMENTS; l++) begin
            if (lane_acc[l]) begin
                present_d[lane_beat[l]][lane_elem[l]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            present_q   <= '{default: '0};
            head_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            present_q   <= present_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_keep_q <= mem_keep_d;
        mem_last_q <= mem_last_d;
        out_data_q <= out_data_d;
        out_keep_q <= out_keep_d;
        out_last_q <= out_last_d;
    end
endmodule
